clk_div_monitor: RTL

CLK_DIV_MONITOR -- requirements
Module: clk_div_monitor

---
 rtl/clk_mon_pkg.sv | 6 +
 rtl/sync_2ff.sv | 13 +
 rtl/clk_div_monitor.sv | 96 +++++++++
 3 files changed

// File: rtl/clk_mon_pkg.sv
// clk_mon_pkg: shared types and defaults for the clock-divider monitor
// Contents: state_t (IDLE/MEASURE FSM encoding), CNT_W_DEF (default counter width)
package clk_mon_pkg;
   localparam int CNT_W_DEF = 8;
   typedef enum logic {IDLE, MEASURE} state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit
// Ports: clk (sampling clock), restn (async active-low reset), d (async input), q (synchronized output)
module sync_2ff (
   input  logic clk,
   input  logic restn,
   input  logic d,
   output logic q
);
   logic s1;
   always_ff @(posedge clk or negedge restn)
      if (!restn) {q, s1} <= 2'b00;
      else        {q, s1} <= {s1, d};
endmodule

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures period/high time of a slow clock, tracks lock and flags errors
// Ports: clk, restn (async active-low), clk_in (async measured clock),
//        period/high_time (last measurement), meas_valid (new-measurement strobe),
//        locked (LOCK_N identical periods), err_period/err_timeout (single-cycle error strobes)
module clk_div_monitor
   import clk_mon_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int LOCK_N  = 4,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             restn,
   input  logic             clk_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             meas_valid,
   output logic             locked,
   output logic             err_period,
   output logic             err_timeout
);
   state_t           state_q, state_d;
   logic             s2, s3, rise, meas, timeout, same;
   logic [CNT_W-1:0] per_cnt, hi_cnt, cap_per, cap_hi;
   logic [3:0]       match, match_nxt;
   logic             cap_v, cap_err;

   sync_2ff u_sync (.clk(clk), .restn(restn), .d(clk_in), .q(s2));

   assign rise    = s2 & ~s3;
   assign meas    = rise && state_q == MEASURE;
   // a rise in the same cycle wins over the timeout
   assign timeout = state_q == MEASURE && per_cnt == CNT_W'(TIMEOUT) && !rise;
   // cap_per doubles as the previous period; match == 0 marks the first measurement
   assign same      = per_cnt == cap_per;
   assign match_nxt = (match == 4'd0 || !same) ? 4'd1 :
                      (match == 4'(LOCK_N) ? match : match + 4'd1);

   always_comb begin
      state_d = state_q;
      if (state_q == IDLE && rise) state_d = MEASURE;
      if (timeout)                 state_d = IDLE;
   end

   // stage A: edge detect, counters, capture of the finished interval
   always_ff @(posedge clk or negedge restn)
      if (!restn) begin
         s3      <= 1'b0;
         state_q <= IDLE;
         per_cnt <= '0;
         hi_cnt  <= '0;
         cap_per <= '0;
         cap_hi  <= '0;
         cap_v   <= 1'b0;
         cap_err <= 1'b0;
         match   <= 4'd0;
      end else begin
         s3      <= s2;
         state_q <= state_d;
         cap_v   <= meas;
         cap_err <= meas && match == 4'(LOCK_N) && !same;
         if (rise) begin
            per_cnt <= CNT_W'(1);
            hi_cnt  <= CNT_W'(1);
            if (state_q == MEASURE) begin
               cap_per <= per_cnt;
               cap_hi  <= hi_cnt;
               match   <= match_nxt;
            end
         end else if (state_q == MEASURE) begin
            per_cnt <= &per_cnt ? per_cnt : per_cnt + CNT_W'(1);
            hi_cnt  <= (s2 && !(&hi_cnt)) ? hi_cnt + CNT_W'(1) : hi_cnt;
         end
         if (timeout) match <= 4'd0;
      end

   // stage B: outputs, all updated together with meas_valid
   always_ff @(posedge clk or negedge restn)
      if (!restn) begin
         period      <= '0;
         high_time   <= '0;
         meas_valid  <= 1'b0;
         locked      <= 1'b0;
         err_period  <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         meas_valid  <= cap_v;
         err_period  <= cap_err;
         err_timeout <= timeout;
         if (cap_v) begin
            period    <= cap_per;
            high_time <= cap_hi;
         end
         locked <= timeout ? 1'b0 : (cap_v ? match == 4'(LOCK_N) : locked);
      end
endmodule
